// File: rtl/key_debounce_multi.sv
// Multi-channel key debouncer with press/release/long/repeat events.
// Each channel owns its synchroniser, debounce counter and hold FSM.
module key_debounce_multi #(
    parameter int unsigned NUM_KEYS   = 4,
    parameter int unsigned CNT_MAX    = 999_999,
    parameter int unsigned LONG_MAX   = 49_999_999,
    parameter int unsigned REPEAT_MAX = 9_999_999,
    parameter bit          REPEAT_EN  = 1'b1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_state,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic [NUM_KEYS-1:0] key_repeat
);

    localparam int CW = $clog2(CNT_MAX);
    localparam int HW = $clog2(LONG_MAX);
    localparam int RW = $clog2(REPEAT_MAX);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MAX - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_MAX - 1);

    localparam logic REL_LVL = ACTIVE_LOW;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HELD,
        ST_LONG
    } state_t;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          pressed;
        logic [CW-1:0] db_cnt;
        logic [CW-1:0] db_cnt_nxt;
        logic          lvl;
        logic          lvl_nxt;
        logic          press_nxt;
        logic          rel_nxt;
        state_t        state;
        state_t        state_nxt;
        logic [HW-1:0] hold_cnt;
        logic [HW-1:0] hold_nxt;
        logic [RW-1:0] rep_cnt;
        logic [RW-1:0] rep_nxt;
        logic          long_nxt;
        logic          rep_p_nxt;
        logic          press_q;
        logic          rel_q;
        logic          long_q;
        logic          rep_q;

        assign pressed = ACTIVE_LOW ? ~sync2 : sync2;

        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                sync1    <= REL_LVL;
                sync2    <= REL_LVL;
                db_cnt   <= '0;
                lvl      <= 1'b0;
                state    <= ST_IDLE;
                hold_cnt <= '0;
                rep_cnt  <= '0;
                press_q  <= 1'b0;
                rel_q    <= 1'b0;
                long_q   <= 1'b0;
                rep_q    <= 1'b0;
            end else begin
                sync1    <= key_in[i];
                sync2    <= sync1;
                db_cnt   <= db_cnt_nxt;
                lvl      <= lvl_nxt;
                state    <= state_nxt;
                hold_cnt <= hold_nxt;
                rep_cnt  <= rep_nxt;
                press_q  <= press_nxt;
                rel_q    <= rel_nxt;
                long_q   <= long_nxt;
                rep_q    <= rep_p_nxt;
            end
        end

        // Any sample equal to the accepted level restarts the count.
        always_comb begin
            db_cnt_nxt = db_cnt + 1'b1;
            lvl_nxt    = lvl;
            press_nxt  = 1'b0;
            rel_nxt    = 1'b0;
            if (pressed == lvl) begin
                db_cnt_nxt = '0;
            end else if (db_cnt == CNT_LAST) begin
                db_cnt_nxt = '0;
                lvl_nxt    = pressed;
                press_nxt  = pressed;
                rel_nxt    = ~pressed;
            end
        end

        // A release accepted on the expiry edge takes priority over long.
        always_comb begin
            state_nxt = state;
            hold_nxt  = hold_cnt;
            rep_nxt   = rep_cnt;
            long_nxt  = 1'b0;
            rep_p_nxt = 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (press_nxt) begin
                        state_nxt = ST_HELD;
                        hold_nxt  = '0;
                        rep_nxt   = '0;
                    end
                end
                ST_HELD: begin
                    if (rel_nxt) begin
                        state_nxt = ST_IDLE;
                        hold_nxt  = '0;
                        rep_nxt   = '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_LONG;
                        long_nxt  = 1'b1;
                        rep_nxt   = '0;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_LONG: begin
                    if (rel_nxt) begin
                        state_nxt = ST_IDLE;
                        hold_nxt  = '0;
                        rep_nxt   = '0;
                    end else if (REPEAT_EN) begin
                        if (rep_cnt == REP_LAST) begin
                            rep_p_nxt = 1'b1;
                            rep_nxt   = '0;
                        end else begin
                            rep_nxt = rep_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                    rep_nxt   = '0;
                end
            endcase
        end

        assign key_state[i]   = lvl;
        assign key_press[i]   = press_q;
        assign key_release[i] = rel_q;
        assign key_long[i]    = long_q;
        assign key_repeat[i]  = rep_q;
    end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: three builds share clock/reset.
// Main build, a no-repeat build and an active-high pad build.
module tb_key_debounce_multi;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [3:0] key_in;
    logic [3:0] ks, kp, kr, kl, kq;
    logic [3:0] nr_key;
    logic [3:0] nr_ks, nr_kp, nr_kr, nr_kl, nr_kq;
    logic [3:0] ah_key;
    logic [3:0] ah_ks, ah_kp, ah_kr, ah_kl, ah_kq;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_press[4], n_rel[4], n_long[4], n_rep[4], n_hi[4];
    int t_press[4], t_rel[4], t_long[4], t_rep0[4], t_rep[4];
    int n_both = 0;
    int n_wide = 0;
    int nr_long, nr_rep;
    int ah_press, ah_rel, ah_hi, ah_tp, ah_tr;
    logic [3:0] prev_p = '0, prev_l = '0, prev_q = '0;

    always #10 clk = ~clk;

    key_debounce_multi #(
        .NUM_KEYS(4), .CNT_MAX(24), .LONG_MAX(100), .REPEAT_MAX(20),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
    ) dut (
        .sys_clk(clk), .sys_rst(sys_rst), .key_in(key_in),
        .key_state(ks), .key_press(kp), .key_release(kr),
        .key_long(kl), .key_repeat(kq)
    );

    key_debounce_multi #(
        .NUM_KEYS(4), .CNT_MAX(24), .LONG_MAX(100), .REPEAT_MAX(20),
        .REPEAT_EN(1'b0), .ACTIVE_LOW(1'b1)
    ) dut_nr (
        .sys_clk(clk), .sys_rst(sys_rst), .key_in(nr_key),
        .key_state(nr_ks), .key_press(nr_kp), .key_release(nr_kr),
        .key_long(nr_kl), .key_repeat(nr_kq)
    );

    key_debounce_multi #(
        .NUM_KEYS(4), .CNT_MAX(24), .LONG_MAX(100), .REPEAT_MAX(20),
        .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
    ) dut_ah (
        .sys_clk(clk), .sys_rst(sys_rst), .key_in(ah_key),
        .key_state(ah_ks), .key_press(ah_kp), .key_release(ah_kr),
        .key_long(ah_kl), .key_repeat(ah_kq)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            n_press[i] = 0; n_rel[i] = 0; n_long[i] = 0;
            n_rep[i] = 0; n_hi[i] = 0;
            t_press[i] = -1; t_rel[i] = -1; t_long[i] = -1;
            t_rep0[i] = -1; t_rep[i] = -1;
        end
        nr_long = 0; nr_rep = 0;
        ah_press = 0; ah_rel = 0; ah_hi = 0; ah_tp = -1; ah_tr = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (kp[i]) begin n_press[i]++; t_press[i] = cyc; end
            if (kr[i]) begin n_rel[i]++; t_rel[i] = cyc; end
            if (kl[i]) begin n_long[i]++; t_long[i] = cyc; end
            if (kq[i]) begin
                n_rep[i]++;
                if (n_rep[i] == 1) t_rep0[i] = cyc;
                t_rep[i] = cyc;
            end
            if (ks[i]) n_hi[i]++;
            if (kp[i] && kr[i]) n_both++;
        end
        n_wide += $countones(kp & prev_p) + $countones(kl & prev_l)
                + $countones(kq & prev_q);
        prev_p = kp; prev_l = kl; prev_q = kq;
        nr_long += $countones(nr_kl);
        nr_rep  += $countones(nr_kq);
        if (ah_kp[0]) begin ah_press++; ah_tp = cyc; end
        if (ah_kr[0]) begin ah_rel++; ah_tr = cyc; end
        if (ah_ks[0]) ah_hi++;
    endtask

    int runs[8] = '{3, 5, 1, 9, 6, 2, 20, 4};
    int rb[4]   = '{3, 5, 2, 10};
    int c, cr, p, r;

    initial begin
        sys_rst = 1'b1;
        key_in  = 4'hF;
        nr_key  = 4'hF;
        ah_key  = 4'h0;
        clr();
        repeat (3) tick();
        chk("rst_state", int'(ks), 0);
        chk("rst_pulses", int'({kp, kr, kl, kq}), 0);
        chk("rst_ah_state", int'(ah_ks), 0);
        sys_rst = 1'b0;
        repeat (5) tick();
        clr();

        // bounce rejection: every low run shorter than 24 cycles
        for (int j = 0; j < 8; j++) begin
            key_in[0] = (j % 2 == 1);
            repeat (runs[j]) tick();
        end
        repeat (40) tick();
        chk("bounce_press", n_press[0], 0);
        chk("bounce_rel", n_rel[0], 0);
        chk("bounce_state", n_hi[0], 0);

        // clean press after bounce, bounced release at exactly 100 held
        clr();
        for (int j = 0; j < 8; j++) begin
            key_in[0] = (j % 2 == 1);
            repeat (runs[j]) tick();
        end
        key_in[0] = 1'b0;
        c = cyc;
        repeat (80) tick();
        for (int j = 0; j < 4; j++) begin
            key_in[0] = (j % 2 == 0);
            repeat (rb[j]) tick();
        end
        key_in[0] = 1'b1;
        cr = cyc;
        repeat (40) tick();
        chk("press_cnt", n_press[0], 1);
        chk("press_time", t_press[0], c + 26);
        chk("rel_cnt", n_rel[0], 1);
        chk("rel_time", t_rel[0], cr + 26);
        chk("held_span", n_hi[0], cr - c);
        chk("rel_beats_long", n_long[0], 0);

        // long press and repeat, both builds
        clr();
        key_in[1] = 1'b0;
        nr_key[1] = 1'b0;
        c = cyc;
        p = c + 26;
        repeat (201) tick();
        key_in[1] = 1'b1;
        nr_key[1] = 1'b1;
        repeat (60) tick();
        chk("lp_press", t_press[1], p);
        chk("lp_long_cnt", n_long[1], 1);
        chk("lp_long_time", t_long[1], p + 100);
        chk("lp_rep_cnt", n_rep[1], 5);
        chk("lp_rep_first", t_rep0[1], p + 120);
        chk("lp_rep_last", t_rep[1], p + 200);
        chk("lp_rel_time", t_rel[1], p + 201);
        chk("nr_long_cnt", nr_long, 1);
        chk("nr_rep_cnt", nr_rep, 0);

        // simultaneous press on two channels
        clr();
        key_in[3:2] = 2'b00;
        c = cyc;
        repeat (40) tick();
        key_in[3:2] = 2'b11;
        repeat (40) tick();
        chk("mc_press2", n_press[2], 1);
        chk("mc_press3", n_press[3], 1);
        chk("mc_t2", t_press[2], c + 26);
        chk("mc_t3", t_press[3], c + 26);
        chk("mc_rel_t2", t_rel[2], c + 66);
        chk("mc_rel_t3", t_rel[3], c + 66);
        chk("mc_ch0_quiet", n_press[0] + n_rel[0] + n_hi[0], 0);

        // reset while in long state
        clr();
        key_in[1] = 1'b0;
        repeat (130) tick();
        chk("rs_long_seen", n_long[1], 1);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        r = cyc;
        chk("rs_state", int'(ks), 0);
        chk("rs_pulses", int'({kp, kr, kl, kq}), 0);
        clr();
        repeat (40) tick();
        chk("rs_no_rel", n_rel[1], 0);
        chk("rs_repress", t_press[1], r + 26);
        key_in[1] = 1'b1;
        repeat (40) tick();
        chk("rs_rel_after", n_rel[1], 1);

        // active-high pads: 30-cycle pulse, then 10-cycle pulse
        clr();
        ah_key[0] = 1'b1;
        c = cyc;
        repeat (30) tick();
        ah_key[0] = 1'b0;
        repeat (40) tick();
        chk("ah_press_cnt", ah_press, 1);
        chk("ah_press_time", ah_tp, c + 26);
        chk("ah_rel_cnt", ah_rel, 1);
        chk("ah_rel_time", ah_tr, c + 56);
        clr();
        ah_key[0] = 1'b1;
        repeat (10) tick();
        ah_key[0] = 1'b0;
        repeat (40) tick();
        chk("ah_short", ah_press + ah_rel + ah_hi, 0);

        chk("never_both", n_both, 0);
        chk("pulse_width", n_wide, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/key_debounce_multi.md
Name: key_debounce_multi

Overview:
- Parametrised multi-channel successor to the single-key debouncer.
- Debounces NUM_KEYS independent mechanical key inputs, each with its own 2-flop synchroniser and debounce counter.
- Per channel, produces a clean level plus one-cycle press, release, long-press and auto-repeat pulses.
- Sits between the board key pads and the control FSMs (menu/mode logic) that consume key events.

Parameters:
- NUM_KEYS, 4: number of independent key channels (>=1).
- CNT_MAX, 20'd999_999: consecutive stable cycles required to accept a level change. 20 ms at 50 MHz; must be >=2.
- LONG_MAX, 26'd49_999_999: held cycles after the accepted press before key_long fires. 1 s at 50 MHz; must be >=2.
- REPEAT_MAX, 24'd9_999_999: period in cycles between key_repeat pulses after key_long. 200 ms; must be >=2.
- REPEAT_EN, 1'b1: 1 enables auto-repeat; 0 means key_repeat stays 0.
- ACTIVE_LOW, 1'b1: 1 means a pad reading 0 is "pressed"; 0 means a pad reading 1 is "pressed".

Ports:
- sys_clk  in  1  system clock; all logic is on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- key_in  in  NUM_KEYS  raw asynchronous key pads; bit i is channel i.
- key_state  out  NUM_KEYS  debounced level per channel; 1 = pressed.
- key_press  out  NUM_KEYS  one-cycle pulse when key_state rises.
- key_release  out  NUM_KEYS  one-cycle pulse when key_state falls.
- key_long  out  NUM_KEYS  one-cycle pulse when a key has been held LONG_MAX cycles.
- key_repeat  out  NUM_KEYS  one-cycle pulse every REPEAT_MAX cycles after key_long while the key stays held.

Behaviour:
- Reset (sys_rst=1 at a rising edge) clears all outputs, counters, FSMs and synchronisers, with synchroniser flops loaded to the "released" pad level (ACTIVE_LOW ? 1 : 0). Reset mid-press aborts the event: no release pulse is emitted, and after reset a still-pressed key must debounce again from zero.
- Synchroniser: 2 flops per channel. pressed_i = ACTIVE_LOW ? ~sync2_i : sync2_i.
- Debounce counter: width $clog2(CNT_MAX). At each edge:
  - if pressed_i == key_state_i, counter <= 0;
  - else if counter == CNT_MAX-1, key_state_i <= pressed_i, counter <= 0, and key_press_i or key_release_i <= 1 for that cycle only;
  - else counter <= counter+1.
  - Any bounce back to the current key_state restarts the count.
- Latency: a pad change first captured by sync1 at edge E0 updates key_state and the pulse register at edge E0+CNT_MAX+1.
- Per-channel FSM:
  - IDLE: key_state=0.
  - HELD: entered on the accepted press; hold counter cleared.
  - LONG: entered when the hold counter reaches LONG_MAX-1, with key_long pulse that cycle.
  - In LONG with REPEAT_EN=1, the repeat counter counts; at REPEAT_MAX-1 it emits a key_repeat pulse and wraps to 0. The first repeat is REPEAT_MAX cycles after key_long.
  - Accepted release from HELD or LONG: key_release pulse, go to IDLE, clear hold/repeat counters. A release accepted in the same edge the hold counter would expire wins: no key_long.
- Hold/repeat counters saturate cleanly with no wrap beyond their max. Widths are $clog2(LONG_MAX) and $clog2(REPEAT_MAX).
- Channels are fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Pulses are never more than one cycle wide. key_press and key_release are never both high on one channel.

Test Plan (CNT_MAX=24, LONG_MAX=100, REPEAT_MAX=20, NUM_KEYS=4, 20 ns clock):
- Bounce rejection: key_in[0] toggles randomly in runs <24 cycles for 50 cycles, then returns high -> key_state[0]=0 and no pulses throughout.
- Clean press: key_in[0] bounces 50 cycles, then holds low for 80 cycles -> exactly one key_press[0], 25 cycles after the last bounce edge is captured. Release with bounce -> exactly one key_release[0]; key_state[0] is high for the stable span only.
- Long/repeat: hold key_in[1] low for 200 cycles past the accepted press -> key_long[1] at +100 cycles, key_repeat[1] at +120, +140, ..., +200. Repeat the run with REPEAT_EN=0 -> no key_repeat.
- Multi-channel: key_in[2] and key_in[3] pressed on the same edge -> key_press[2] and key_press[3] high in the same cycle. Channel 0 stays quiet.
- Reset mid-operation: assert sys_rst for 1 cycle while key 1 is in LONG -> all outputs 0 on the next cycle with no release pulse. key_state[1] re-rises 26 cycles later if still held.
- ACTIVE_LOW=0 build: a high pad pulse of 30 cycles -> key_press then key_release. A 10-cycle pulse -> nothing.
